// File: rtl/bcd_updown_display_counter_if.sv
// Signal bundle for the BCD up/down display counter.
// The master drives the controls and load value; the slave (counter) returns the count, segments and flags.
interface bcd_updown_display_counter_if #(
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   hex_out;
  logic                  tick_led;
  logic                  at_limit;
  logic                  overflow;
  logic                  load_err;

  modport master (
    output enable, up_down, load, load_value,
    input  bcd_out, hex_out, tick_led, at_limit, overflow, load_err
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output bcd_out, hex_out, tick_led, at_limit, overflow, load_err
  );
endinterface

// File: rtl/bcd_updown_display_counter.sv
// N-digit BCD up/down counter with prescaler, parallel load, wrap/saturate limits
// and a registered active-low 7-segment decode with optional leading-zero blanking.
module bcd_updown_display_counter #(
  parameter int DIGITS    = 3,
  parameter int CLK_FREQ  = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int MAX_VALUE = 999,
  parameter int WRAP_MODE = 1,
  parameter int BLANK_LZ  = 1
) (
  input logic clk,
  input logic rst_a,
  bcd_updown_display_counter_if.slave bus
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = 4 * DIGITS;
  localparam int HW  = 7 * DIGITS;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Walk from the top digit down; a digit blanks only while every digit above it is also zero.
  function automatic logic [HW-1:0] decode_display(input logic [BW-1:0] v);
    logic [HW-1:0] r;
    logic          lead;
    r    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && (v[4*i +: 4] == 4'd0);
      r[7*i +: 7] = ((BLANK_LZ != 0) && lead && (i > 0)) ? 7'b1111111 : seg7(v[4*i +: 4]);
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_VALUE);
  localparam logic [HW-1:0] HEX_RST = decode_display('0);

  logic [PW-1:0] presc;
  logic [BW-1:0] count;
  logic [HW-1:0] hex_q;
  logic          tick_led_q;
  logic          overflow_q;
  logic          load_err_q;

  logic [BW-1:0] inc_val;
  logic [BW-1:0] dec_val;
  logic [BW-1:0] next_count;
  logic          carry;
  logic          borrow;
  logic          at_max;
  logic          at_zero;
  logic          wrap_evt;
  logic          load_ok;
  logic          tick;

  always_comb begin
    inc_val    = count;
    dec_val    = count;
    carry      = 1'b1;
    borrow     = 1'b1;
    next_count = count;
    wrap_evt   = 1'b0;
    load_ok    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (bus.load_value[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    // With every digit valid, BCD ordering matches unsigned ordering of the packed vector.
    if (bus.load_value > MAX_BCD) load_ok = 1'b0;

    at_max  = (count == MAX_BCD);
    at_zero = (count == '0);
    if (bus.up_down) begin
      if (!at_max) begin
        next_count = inc_val;
      end else if (WRAP_MODE != 0) begin
        next_count = '0;
        wrap_evt   = 1'b1;
      end
    end else begin
      if (!at_zero) begin
        next_count = dec_val;
      end else if (WRAP_MODE != 0) begin
        next_count = MAX_BCD;
        wrap_evt   = 1'b1;
      end
    end
  end

  assign tick = bus.enable && (presc == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      presc      <= '0;
      count      <= '0;
      hex_q      <= HEX_RST;
      tick_led_q <= 1'b0;
      overflow_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      load_err_q <= 1'b0;
      hex_q      <= decode_display(count);
      // A load wins over a coincident tick; that tick is simply dropped.
      if (bus.load) begin
        if (load_ok) begin
          count <= bus.load_value;
          presc <= '0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (tick) begin
        presc      <= '0;
        count      <= next_count;
        tick_led_q <= ~tick_led_q;
        overflow_q <= wrap_evt;
      end else if (bus.enable) begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign bus.bcd_out  = count;
  assign bus.hex_out  = hex_q;
  assign bus.tick_led = tick_led_q;
  assign bus.overflow = overflow_q;
  assign bus.load_err = load_err_q;
  assign bus.at_limit = bus.up_down ? (count == MAX_BCD) : (count == '0);
endmodule

// File: tb/tb_bcd_updown_display_counter.sv
// Directed bench for bcd_updown_display_counter: three instances (wrap/999, saturate/999
// without blanking, wrap/500) share clock and reset and are exercised one at a time.
module tb_bcd_updown_display_counter;
  localparam logic [6:0] SEG_BL = 7'b1111111;
  localparam logic [6:0] SEG0   = 7'b1000000;
  localparam logic [6:0] SEG1   = 7'b1111001;
  localparam logic [6:0] SEG2   = 7'b0100100;
  localparam logic [6:0] SEG5   = 7'b0010010;
  localparam logic [6:0] SEG7   = 7'b1111000;

  logic clk;
  logic rst_a;
  int   n_vec;
  int   n_err;
  int   ovf_cnt;
  int   led_tog;
  logic led_prev;

  bcd_updown_display_counter_if #(.DIGITS(3)) if_w ();
  bcd_updown_display_counter_if #(.DIGITS(3)) if_s ();
  bcd_updown_display_counter_if #(.DIGITS(3)) if_m ();

  bcd_updown_display_counter #(.DIGITS(3), .CLK_FREQ(10), .TICK_HZ(1), .MAX_VALUE(999),
    .WRAP_MODE(1), .BLANK_LZ(1)) u_wrap (.clk(clk), .rst_a(rst_a), .bus(if_w));
  bcd_updown_display_counter #(.DIGITS(3), .CLK_FREQ(10), .TICK_HZ(1), .MAX_VALUE(999),
    .WRAP_MODE(0), .BLANK_LZ(0)) u_sat (.clk(clk), .rst_a(rst_a), .bus(if_s));
  bcd_updown_display_counter #(.DIGITS(3), .CLK_FREQ(10), .TICK_HZ(1), .MAX_VALUE(500),
    .WRAP_MODE(1), .BLANK_LZ(1)) u_m500 (.clk(clk), .rst_a(rst_a), .bus(if_m));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_a = 1'b1;
    if_w.enable = 0; if_w.up_down = 0; if_w.load = 0; if_w.load_value = '0;
    if_s.enable = 0; if_s.up_down = 0; if_s.load = 0; if_s.load_value = '0;
    if_m.enable = 0; if_m.up_down = 0; if_m.load = 0; if_m.load_value = '0;
    step(2);

    // Reset state
    check("rst_bcd",      32'(if_w.bcd_out), 32'h000);
    check("rst_hex_blank", 32'(if_w.hex_out), 32'({SEG_BL, SEG_BL, SEG0}));
    check("rst_hex_noblank", 32'(if_s.hex_out), 32'({SEG0, SEG0, SEG0}));
    check("rst_led",      32'(if_w.tick_led), 32'd0);
    check("rst_ovf",      32'(if_w.overflow), 32'd0);
    check("rst_lerr",     32'(if_w.load_err), 32'd0);
    check("rst_at_limit", 32'(if_w.at_limit), 32'd1);

    // 1: count up, ticks at cycles 10 and 20
    rst_a = 1'b0;
    if_w.enable = 1; if_w.up_down = 1;
    step(9);
    check("t1_pre_tick", 32'(if_w.bcd_out), 32'h000);
    step(1);
    check("t1_tick1_bcd", 32'(if_w.bcd_out), 32'h001);
    check("t1_tick1_led", 32'(if_w.tick_led), 32'd1);
    check("t1_hex_lag", 32'(if_w.hex_out), 32'({SEG_BL, SEG_BL, SEG0}));
    step(1);
    check("t1_hex_1", 32'(if_w.hex_out), 32'({SEG_BL, SEG_BL, SEG1}));
    step(14);
    check("t1_bcd_25", 32'(if_w.bcd_out), 32'h002);
    check("t1_led_25", 32'(if_w.tick_led), 32'd0);
    check("t1_hex_25", 32'(if_w.hex_out), 32'({SEG_BL, SEG_BL, SEG2}));

    // 2: load 998, wrap 999 -> 000
    if_w.load = 1; if_w.load_value = 12'h998;
    step(1);
    if_w.load = 0;
    check("t2_load", 32'(if_w.bcd_out), 32'h998);
    ovf_cnt = 0;
    for (int i = 1; i <= 21; i++) begin
      step(1);
      if (if_w.overflow) ovf_cnt++;
      if (i == 10) begin
        check("t2_999", 32'(if_w.bcd_out), 32'h999);
        check("t2_at_limit", 32'(if_w.at_limit), 32'd1);
      end
      if (i == 20) begin
        check("t2_wrap_bcd", 32'(if_w.bcd_out), 32'h000);
        check("t2_wrap_ovf", 32'(if_w.overflow), 32'd1);
        check("t2_at_limit_0", 32'(if_w.at_limit), 32'd0);
      end
    end
    check("t2_ovf_count", 32'(ovf_cnt), 32'd1);

    // 4: valid then invalid load with counting disabled
    if_w.enable = 0;
    if_w.load = 1; if_w.load_value = 12'h345;
    step(1);
    check("t4_load_345", 32'(if_w.bcd_out), 32'h345);
    check("t4_lerr_ok", 32'(if_w.load_err), 32'd0);
    if_w.load_value = 12'h1A0;
    step(1);
    check("t4_lerr_1a0", 32'(if_w.load_err), 32'd1);
    check("t4_bcd_kept", 32'(if_w.bcd_out), 32'h345);
    if_w.load = 0;
    step(1);
    check("t4_lerr_clr", 32'(if_w.load_err), 32'd0);

    // 5: load on the exact tick cycle while counting down
    if_w.up_down = 0; if_w.enable = 1;
    step(9);
    led_prev = if_w.tick_led;
    if_w.load = 1; if_w.load_value = 12'h100;
    step(1);
    if_w.load = 0;
    check("t5_load_wins", 32'(if_w.bcd_out), 32'h100);
    check("t5_led_hold", 32'(if_w.tick_led), 32'(led_prev));
    step(9);
    check("t5_presc_restart", 32'(if_w.bcd_out), 32'h100);
    step(1);
    check("t5_borrow", 32'(if_w.bcd_out), 32'h099);

    // 4b: MAX_VALUE = 500 limits and wraps
    if_m.up_down = 1;
    if_m.load = 1; if_m.load_value = 12'h501;
    step(1);
    check("m_lerr_501", 32'(if_m.load_err), 32'd1);
    check("m_bcd_kept", 32'(if_m.bcd_out), 32'h000);
    if_m.load_value = 12'h500;
    step(1);
    if_m.load = 0;
    check("m_load_500", 32'(if_m.bcd_out), 32'h500);
    check("m_lerr_500", 32'(if_m.load_err), 32'd0);
    check("m_at_limit", 32'(if_m.at_limit), 32'd1);
    if_m.enable = 1;
    step(10);
    check("m_wrap_up", 32'(if_m.bcd_out), 32'h000);
    check("m_wrap_up_ovf", 32'(if_m.overflow), 32'd1);
    if_m.up_down = 0;
    step(10);
    check("m_wrap_dn", 32'(if_m.bcd_out), 32'h500);
    check("m_wrap_dn_ovf", 32'(if_m.overflow), 32'd1);
    if_m.enable = 0;

    // 3: saturate at zero counting down
    if_s.enable = 1; if_s.up_down = 0;
    ovf_cnt  = 0;
    led_tog  = 0;
    led_prev = if_s.tick_led;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (if_s.overflow) ovf_cnt++;
      if (if_s.tick_led != led_prev) led_tog++;
      led_prev = if_s.tick_led;
    end
    check("t3_bcd_hold", 32'(if_s.bcd_out), 32'h000);
    check("t3_no_ovf", 32'(ovf_cnt), 32'd0);
    check("t3_led_toggles", 32'(led_tog), 32'd3);
    check("t3_at_limit", 32'(if_s.at_limit), 32'd1);

    // Carry across digits and saturation at the top
    if_s.enable = 0; if_s.up_down = 1;
    if_s.load = 1; if_s.load_value = 12'h199;
    step(1);
    if_s.load = 0; if_s.enable = 1;
    step(10);
    check("s_carry", 32'(if_s.bcd_out), 32'h200);
    step(1);
    check("s_hex_200", 32'(if_s.hex_out), 32'({SEG2, SEG0, SEG0}));
    if_s.load = 1; if_s.load_value = 12'h999;
    step(1);
    if_s.load = 0;
    step(10);
    check("s_sat_top", 32'(if_s.bcd_out), 32'h999);
    check("s_sat_no_ovf", 32'(if_s.overflow), 32'd0);
    if_s.enable = 0;

    // 6: asynchronous reset mid-prescale
    if_w.load = 1; if_w.load_value = 12'h057;
    step(1);
    if_w.load = 0;
    check("t6_load_057", 32'(if_w.bcd_out), 32'h057);
    step(1);
    check("t6_hex_057", 32'(if_w.hex_out), 32'({SEG_BL, SEG5, SEG7}));
    step(3);
    #2 rst_a = 1'b1;
    #1;
    check("t6_async_bcd", 32'(if_w.bcd_out), 32'h000);
    check("t6_async_hex", 32'(if_w.hex_out), 32'({SEG_BL, SEG_BL, SEG0}));
    check("t6_async_led", 32'(if_w.tick_led), 32'd0);
    check("t6_async_at_limit", 32'(if_w.at_limit), 32'd1);
    step(1);
    rst_a = 1'b0;
    if_w.up_down = 1;
    step(9);
    check("t6_no_partial", 32'(if_w.bcd_out), 32'h000);
    step(1);
    check("t6_first_tick", 32'(if_w.bcd_out), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_updown_display_counter.md
Name: bcd_updown_display_counter

Overview:
Parametrised N-digit decimal up/down counter for the board display path. It advances at a programmable rate derived from the system clock by an internal prescaler. The count is held natively in BCD, so no divide/modulo is needed, and each digit is decoded to an active-low 7-segment pattern. It replaces the fixed 5-bit counter plus binary-to-digit split in the top-level display wrapper, and adds:
- synchronous parallel load
- wrap or saturate limit modes
- leading-zero blanking
- limit and overflow flags

Parameters:
DIGITS, 3, number of BCD digits and 7-segment outputs (1..6)
CLK_FREQ, 50000000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz. DIV = CLK_FREQ/TICK_HZ, integer, must be >= 2.
MAX_VALUE, 999, upper count limit (decimal, < 10^DIGITS)
WRAP_MODE, 1, 1 = wrap at the limits, 0 = saturate at the limits
BLANK_LZ, 1, 1 = blank leading-zero digits (digit 0 is never blanked)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_a  input  1  asynchronous active-high reset
enable  input  1  1 = prescaler runs and counting is allowed
up_down  input  1  1 = count up, 0 = count down; sampled on the tick cycle
load  input  1  synchronous load strobe
load_value  input  4*DIGITS  BCD load value; digit 0 is in bits [3:0]
bcd_out  output  4*DIGITS  registered BCD count
hex_out  output  7*DIGITS  active-low segments per digit, {g,f,e,d,c,b,a}; digit 0 is in bits [6:0]
tick_led  output  1  toggles on every count tick
at_limit  output  1  high while count == MAX_VALUE (up) or count == 0 (down)
overflow  output  1  one-cycle pulse on a wrap event
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
Reset (rst_a high, asynchronous):
- prescaler = 0, count = 0, tick_led = 0, overflow = 0, load_err = 0.
- hex_out digit 0 = 7'b1000000 ("0").
- Other hex_out digits = 7'b1111111 if BLANK_LZ, else 7'b1000000.
- at_limit reflects a count of 0: it is 1 when up_down = 0.
- Deasserting rst_a mid-operation restarts cleanly from these values; no partial tick survives.

Prescaler:
- Counts 0..DIV-1 while enable = 1.
- tick is an internal one-cycle pulse in the cycle where prescaler == DIV-1; the prescaler returns to 0 on the next edge.
- enable = 0 holds the prescaler value; it does not clear it.

Count update (registered): bcd_out changes on the edge following the tick cycle.
Up direction:
- count < MAX_VALUE: BCD increment, where digit 9 becomes 0 and carries into the next digit.
- count == MAX_VALUE and WRAP_MODE = 1: next count = 0, overflow = 1 for one cycle.
- count == MAX_VALUE and WRAP_MODE = 0: count holds, no overflow.
Down direction:
- count > 0: BCD decrement, where digit 0 becomes 9 and borrows from the next digit.
- count == 0 and WRAP_MODE = 1: next count = MAX_VALUE, overflow = 1.
- count == 0 and WRAP_MODE = 0: count holds, no overflow.

Load:
- load has priority over a tick in the same cycle; that tick is discarded.
- Valid load: every digit of load_value is <= 9 and the value is <= MAX_VALUE. Then count = load_value on the next edge and the prescaler clears to 0.
- Invalid load: count and prescaler are unchanged, and load_err pulses for one cycle.
- load acts even when enable = 0.

tick_led:
- Toggles on every tick, including ticks where a saturated count holds.
- Does not toggle on load.

at_limit:
- Combinational from the registered count and the current up_down.

hex_out:
- Registered decode of bcd_out, so it lags bcd_out by one cycle.
- Digit values 0..9 use the standard active-low patterns: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- With BLANK_LZ = 1, a digit i > 0 is blanked (1111111) when it and every higher digit are 0.

Test Plan:
(All cases use CLK_FREQ=10, TICK_HZ=1, so DIV=10, with DIGITS=3 and MAX_VALUE=999 unless stated otherwise.)
1. Reset, then enable = 1, up_down = 1 for 25 clocks -> ticks occur at cycles 10 and 20; bcd_out = 12'h002; tick_led = 0; hex_out = {1111111, 1111111, 0100100}.
2. Load 12'h998, then run up for 2 ticks with WRAP_MODE = 1 -> count goes 999 then 000. overflow pulses once at the 999->000 edge. at_limit = 1 while the count is 999.
3. WRAP_MODE = 0, count 0, up_down = 0, 3 ticks -> bcd_out stays 000; overflow is never asserted; tick_led toggles 3 times.
4. Load 12'h1A0 -> load_err pulses and bcd_out is unchanged. With MAX_VALUE = 500, a load of 12'h501 is also rejected.
5. Assert load 12'h100 on the exact tick cycle with up_down = 0 -> bcd_out = 100 (not 099), and the prescaler restarts from 0.
6. Assert rst_a asynchronously mid-prescale at count 12'h057 -> all outputs return to their reset values immediately, without waiting for a clock edge. The first tick after release arrives 10 cycles later.
